dm_mem_read_master: RTL and testbench
=====================================

# dm_mem_read_master

Debug-module-side initiator for the data memory's debug read port. It accepts a read command from the debug transport with a start word address, a beat count and an autoincrement flag. It drives `dm_Mem_rd_en_o`/`dm_Mem_rd_address_o` and samples the memory-driven data bus, then returns each word over a valid/ready response channel. It sits between the DMI register block and the Data_Memory debug port. It lets the external debugger read memory without stalling the core.

## Interface
- `MEM_DEPTH`, 32: number of 32-bit words in data memory; word addresses `>= MEM_DEPTH` are out of range.
- `CNT_W`, 6: width of the beat-count field; the maximum burst is `2**CNT_W - 1` beats.
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `cmd_valid_i`, in, 1: command request.
- `cmd_ready_o`, out, 1: command accepted when high together with `cmd_valid_i`; high only in IDLE.
- `cmd_addr_i`, in, 32: start word address.
- `cmd_count_i`, in, `CNT_W`: number of beats; 0 is treated as 1.
- `cmd_autoinc_i`, in, 1: 1 increments the address by 1 per beat; 0 rereads the same address.
- `abort_i`, in, 1: cancels any command in progress.
- `rsp_valid_o`, out, 1: response word valid.
- `rsp_ready_i`, in, 1: response consumed when high together with `rsp_valid_o`.
- `rsp_data_o`, out, 32: captured word.
- `rsp_last_o`, out, 1: final beat of the command.
- `rsp_err_o`, out, 1: out-of-range beat; `rsp_data_o` is 0 on such a beat.
- `busy_o`, out, 1: high whenever the state is not IDLE.
- `dm_Mem_rd_en_o`, out, 1: memory debug read enable.
- `dm_Mem_rd_address_o`, out, 32: memory debug read word address.
- `dm_Mem_rd_wr_data_i`, in, 32: the shared data net, sampled only; this block never drives it.

## Operation
- States: IDLE, READ, HOLD.
- **IDLE**
  - `cmd_ready_o`=1.
  - On accept, latch addr, count (0→1), autoinc and go to READ.
- **READ** (exactly one cycle)
  - If addr `< MEM_DEPTH`: drive `dm_Mem_rd_en_o`=1 and `dm_Mem_rd_address_o`=addr, and register `dm_Mem_rd_wr_data_i` into `rsp_data_o` at the clock edge, err=0.
  - If addr is out of range: keep `dm_Mem_rd_en_o`=0, capture data 0, err=1.
  - Set last=1 when remaining==1 or err=1.
  - Go to HOLD.
- **HOLD**
  - `rsp_valid_o`=1; data/last/err are stable until the handshake.
  - On handshake with last=1: go to IDLE.
  - On handshake with last=0: decrement remaining, add autoinc to addr, go to READ.
- **Error termination**: an out-of-range beat always ends the command; no further beats are issued.
- **Address arithmetic**: 32-bit unsigned. An increment that reaches `MEM_DEPTH` produces an error on the next beat; it does not wrap to 0.
- **Bus idle values**: outside READ, `dm_Mem_rd_en_o`=0 and `dm_Mem_rd_address_o`=0, so the memory tri-states the data net.
- **Abort**
  - `abort_i`=1 in any state forces IDLE at the next edge.
  - `rsp_valid_o` drops that same edge and no response is completed.
  - `abort_i` wins over a simultaneous command accept or response handshake.
- **Reset**
  - `rst_i` at any point, including mid-burst, returns to IDLE.
  - All outputs reset to 0 except `cmd_ready_o`, which resets to 1.

## Timing
- Cycle 0: command handshake.
- Cycle 1: READ, with `dm_Mem_rd_en_o` high for exactly this cycle.
- Cycle 2: first `rsp_valid_o`.
- With `rsp_ready_i` held at 1, a beat completes every 2 cycles, so an N-beat burst occupies 2N cycles after accept.
- Memory read is combinational; data is sampled at the end of the READ cycle.
- `rsp_*` outputs are registered; no combinational path from `rsp_ready_i` to any output.
- `cmd_ready_o` returns high the cycle after the last handshake. A new command can be accepted then: cycle 2N+1 with no backpressure.

## Test plan
- **Single read**: memory word 12 = 0x00000008; command addr=12, count=1, autoinc=1.
  - Response: one beat, data=0x00000008, last=1, err=0.
  - `dm_Mem_rd_en_o` is high for exactly 1 cycle.
- **Burst**: preload words 10..13 = 0xA0..0xA3; command addr=10, count=4, autoinc=1.
  - Response: 4 beats 0xA0, 0xA1, 0xA2, 0xA3; last only on the 4th; 8 cycles total.
- **Backpressure and no increment**: word 5 = 0x55; command addr=5, count=3, autoinc=0; `rsp_ready_i` held low 3 cycles per beat.
  - Response: 3 beats of 0x55.
  - `rsp_data_o`/`rsp_last_o` stable while stalled.
  - No extra `dm_Mem_rd_en_o` pulses during stalls.
- **Range edge**: command addr=30, count=4.
  - Response: beats from 30 and 31 with err=0, then a third beat with data=0, err=1, last=1; only 3 beats.
  - Separately, command addr=40: one beat with err=1, last=1, and `dm_Mem_rd_en_o` never asserted.
- **Count zero**: command count=0, addr=12.
  - Response: exactly one beat, data=0x00000008, last=1.
- **Abort and reset**
  - Assert `abort_i` during the HOLD of beat 2 of a 4-beat burst: `rsp_valid_o` drops the next cycle, `busy_o`=0, and a new command is accepted the following cycle.
  - Repeat with `rst_i` mid-burst: all outputs are 0 and `cmd_ready_o`=1 after the edge.

Source files
------------

// File: rtl/dm_mem_read_master_if.sv
// Debug read bundle: command channel, response channel and the memory debug read port.
// The master modport is the initiator's view; the slave modport is the view of the transport and memory side.
interface dm_mem_read_master_if #(
  parameter int CNT_W = 6
);
  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic [31:0]      cmd_addr_i;
  logic [CNT_W-1:0] cmd_count_i;
  logic             cmd_autoinc_i;
  logic             abort_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [31:0]      rsp_data_o;
  logic             rsp_last_o;
  logic             rsp_err_o;
  logic             busy_o;
  logic             dm_Mem_rd_en_o;
  logic [31:0]      dm_Mem_rd_address_o;
  logic [31:0]      dm_Mem_rd_wr_data_i;

  modport master (
    input  cmd_valid_i, cmd_addr_i, cmd_count_i, cmd_autoinc_i, abort_i,
    input  rsp_ready_i, dm_Mem_rd_wr_data_i,
    output cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_last_o, rsp_err_o, busy_o,
    output dm_Mem_rd_en_o, dm_Mem_rd_address_o
  );

  modport slave (
    output cmd_valid_i, cmd_addr_i, cmd_count_i, cmd_autoinc_i, abort_i,
    output rsp_ready_i, dm_Mem_rd_wr_data_i,
    input  cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_last_o, rsp_err_o, busy_o,
    input  dm_Mem_rd_en_o, dm_Mem_rd_address_o
  );
endinterface

// File: rtl/dm_mem_read_master.sv
// Debug-side burst reader of data memory, returning words over valid/ready.
// Latency: one READ cycle after accept, the response is valid the next cycle; each beat takes 2 cycles.
// Backpressure: a beat waits in HOLD with stable data until rsp_ready_i; no memory reads are issued while stalled.
module dm_mem_read_master #(
  parameter int MEM_DEPTH = 32,
  parameter int CNT_W     = 6
) (
  input logic                  clk_i,
  input logic                  rst_i,
  dm_mem_read_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;

  typedef struct packed {
    logic [31:0]      addr;
    logic [CNT_W-1:0] remain;
    logic             autoinc;
  } cmd_t;

  localparam logic [31:0] DEPTH = 32'(MEM_DEPTH);

  state_t      state;
  cmd_t        cmd_q;
  logic [31:0] next_addr;
  logic        in_range;
  logic        cmd_fire;
  logic        rsp_fire;

  assign next_addr = cmd_q.addr + {31'd0, cmd_q.autoinc};
  assign in_range  = cmd_q.addr < DEPTH;
  assign cmd_fire  = bus.cmd_valid_i && bus.cmd_ready_o;
  assign rsp_fire  = bus.rsp_valid_o && bus.rsp_ready_i;

  always_ff @(posedge clk_i) begin
    // Abort behaves exactly like reset so it also beats any same-cycle handshake.
    if (rst_i || bus.abort_i) begin
      state                   <= IDLE;
      cmd_q                   <= '0;
      bus.cmd_ready_o         <= 1'b1;
      bus.busy_o              <= 1'b0;
      bus.rsp_valid_o         <= 1'b0;
      bus.rsp_data_o          <= '0;
      bus.rsp_last_o          <= 1'b0;
      bus.rsp_err_o           <= 1'b0;
      bus.dm_Mem_rd_en_o      <= 1'b0;
      bus.dm_Mem_rd_address_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            cmd_q.addr              <= bus.cmd_addr_i;
            cmd_q.remain            <= (bus.cmd_count_i == '0) ? CNT_W'(1) : bus.cmd_count_i;
            cmd_q.autoinc           <= bus.cmd_autoinc_i;
            bus.dm_Mem_rd_en_o      <= bus.cmd_addr_i < DEPTH;
            bus.dm_Mem_rd_address_o <= (bus.cmd_addr_i < DEPTH) ? bus.cmd_addr_i : '0;
            bus.cmd_ready_o         <= 1'b0;
            bus.busy_o              <= 1'b1;
            state                   <= READ;
          end
        end
        READ: begin
          bus.rsp_data_o          <= in_range ? bus.dm_Mem_rd_wr_data_i : '0;
          bus.rsp_err_o           <= !in_range;
          bus.rsp_last_o          <= (cmd_q.remain == CNT_W'(1)) || !in_range;
          bus.rsp_valid_o         <= 1'b1;
          bus.dm_Mem_rd_en_o      <= 1'b0;
          bus.dm_Mem_rd_address_o <= '0;
          state                   <= HOLD;
        end
        HOLD: begin
          if (rsp_fire) begin
            bus.rsp_valid_o <= 1'b0;
            if (bus.rsp_last_o) begin
              bus.cmd_ready_o <= 1'b1;
              bus.busy_o      <= 1'b0;
              state           <= IDLE;
            end else begin
              // An increment past the top is not wrapped; it becomes an error beat.
              cmd_q.remain            <= cmd_q.remain - CNT_W'(1);
              cmd_q.addr              <= next_addr;
              bus.dm_Mem_rd_en_o      <= next_addr < DEPTH;
              bus.dm_Mem_rd_address_o <= (next_addr < DEPTH) ? next_addr : '0;
              state                   <= READ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dm_mem_read_master.sv
// Directed self-checking bench for dm_mem_read_master with a combinational memory model.
module tb_dm_mem_read_master;
  localparam int CNT_W = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dm_mem_read_master_if #(.CNT_W(CNT_W)) bus ();

  dm_mem_read_master #(.MEM_DEPTH(32), .CNT_W(CNT_W)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  logic [31:0] mem [32];
  // Drive a poison pattern when not enabled so unqualified sampling is visible.
  assign bus.dm_Mem_rd_wr_data_i = (bus.dm_Mem_rd_en_o && bus.dm_Mem_rd_address_o < 32)
                                   ? mem[bus.dm_Mem_rd_address_o[4:0]] : 32'hDEAD_BEEF;

  int cyc = 0;
  int en_total = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.dm_Mem_rd_en_o) en_total <= en_total + 1;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] d;
  logic        l, e, st;
  int          e0, t0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue_cmd(input logic [31:0] a, input logic [CNT_W-1:0] c, input logic ai);
    int n = 0;
    bus.cmd_addr_i = a; bus.cmd_count_i = c; bus.cmd_autoinc_i = ai; bus.cmd_valid_i = 1'b1;
    while (bus.cmd_ready_o !== 1'b1 && n < 40) begin tick(); n++; end
    if (n >= 40) begin
      n_chk++; n_fail++;
      $display("FAIL cmd_timeout: cmd_ready_o=%b required 1", bus.cmd_ready_o);
    end
    tick();
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic get_beat(input int stall, output logic [31:0] bd, output logic bl,
                          output logic be, output logic stable);
    int n = 0;
    stable = 1'b1;
    while (bus.rsp_valid_o !== 1'b1 && n < 40) begin tick(); n++; end
    if (n >= 40) begin
      n_chk++; n_fail++;
      $display("FAIL beat_timeout: rsp_valid_o=%b required 1", bus.rsp_valid_o);
    end
    bd = bus.rsp_data_o; bl = bus.rsp_last_o; be = bus.rsp_err_o;
    for (int i = 0; i < stall; i++) begin
      tick();
      if (bus.rsp_valid_o !== 1'b1 || bus.rsp_data_o !== bd || bus.rsp_last_o !== bl || bus.rsp_err_o !== be)
        stable = 1'b0;
    end
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    bus.cmd_valid_i = 0; bus.cmd_addr_i = 0; bus.cmd_count_i = 0; bus.cmd_autoinc_i = 0;
    bus.abort_i = 0; bus.rsp_ready_i = 0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    n_chk++;
    if ({bus.cmd_ready_o, bus.rsp_valid_o, bus.busy_o, bus.dm_Mem_rd_en_o, bus.rsp_last_o, bus.rsp_err_o} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 100000",
               {bus.cmd_ready_o, bus.rsp_valid_o, bus.busy_o, bus.dm_Mem_rd_en_o, bus.rsp_last_o, bus.rsp_err_o});
    end
    n_chk++;
    if (bus.rsp_data_o !== 32'd0 || bus.dm_Mem_rd_address_o !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_buses: data=%h addr=%h required 0", bus.rsp_data_o, bus.dm_Mem_rd_address_o);
    end
  endtask

  task automatic test_single_read();
    mem[12] = 32'h0000_0008;
    e0 = en_total;
    issue_cmd(32'd12, 6'd1, 1'b1);
    n_chk++;
    if (bus.dm_Mem_rd_en_o !== 1'b1 || bus.dm_Mem_rd_address_o !== 32'd12 || bus.cmd_ready_o !== 1'b0 || bus.busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL single_read_cycle: en=%b addr=%0d rdy=%b busy=%b required 1 12 0 1",
               bus.dm_Mem_rd_en_o, bus.dm_Mem_rd_address_o, bus.cmd_ready_o, bus.busy_o);
    end
    get_beat(0, d, l, e, st);
    n_chk++;
    if (d !== 32'h8 || l !== 1'b1 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL single_read_beat: data=%h last=%b err=%b required 00000008 1 0", d, l, e);
    end
    n_chk++;
    if (bus.cmd_ready_o !== 1'b1 || en_total - e0 !== 1) begin
      n_fail++;
      $display("FAIL single_read_done: rdy=%b en_cycles=%0d required 1 1", bus.cmd_ready_o, en_total - e0);
    end
  endtask

  task automatic test_burst();
    for (int i = 0; i < 4; i++) mem[10+i] = 32'hA0 + i;
    e0 = en_total;
    issue_cmd(32'd10, 6'd4, 1'b1);
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      get_beat(0, d, l, e, st);
      n_chk++;
      if (d !== 32'hA0 + i || l !== (i == 3) || e !== 1'b0) begin
        n_fail++;
        $display("FAIL burst_beat%0d: data=%h last=%b err=%b required %h %b 0", i, d, l, e, 32'hA0 + i, (i == 3));
      end
    end
    n_chk++;
    if (cyc - t0 !== 8 || en_total - e0 !== 4 || bus.cmd_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL burst_timing: cycles=%0d en=%0d rdy=%b required 8 4 1", cyc - t0, en_total - e0, bus.cmd_ready_o);
    end
  endtask

  task automatic test_backpressure();
    mem[5] = 32'h55;
    e0 = en_total;
    issue_cmd(32'd5, 6'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      get_beat(3, d, l, e, st);
      n_chk++;
      if (d !== 32'h55 || l !== (i == 2) || e !== 1'b0 || st !== 1'b1) begin
        n_fail++;
        $display("FAIL backpressure_beat%0d: data=%h last=%b err=%b stable=%b required 00000055 %b 0 1",
                 i, d, l, e, st, (i == 2));
      end
    end
    n_chk++;
    if (en_total - e0 !== 3) begin
      n_fail++;
      $display("FAIL backpressure_en: en_cycles=%0d required 3", en_total - e0);
    end
  endtask

  task automatic test_range_edge();
    mem[30] = 32'h1E1E; mem[31] = 32'h1F1F;
    e0 = en_total;
    issue_cmd(32'd30, 6'd4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      get_beat(0, d, l, e, st);
      n_chk++;
      if (d !== ((i == 0) ? 32'h1E1E : (i == 1) ? 32'h1F1F : 32'h0) || e !== (i == 2) || l !== (i == 2)) begin
        n_fail++;
        $display("FAIL range_beat%0d: data=%h last=%b err=%b", i, d, l, e);
      end
    end
    repeat (4) tick();
    n_chk++;
    if (bus.rsp_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || en_total - e0 !== 2) begin
      n_fail++;
      $display("FAIL range_end: valid=%b busy=%b en=%0d required 0 0 2", bus.rsp_valid_o, bus.busy_o, en_total - e0);
    end
    e0 = en_total;
    issue_cmd(32'd40, 6'd3, 1'b1);
    get_beat(0, d, l, e, st);
    n_chk++;
    if (d !== 32'h0 || l !== 1'b1 || e !== 1'b1) begin
      n_fail++;
      $display("FAIL range_oob_beat: data=%h last=%b err=%b required 00000000 1 1", d, l, e);
    end
    repeat (3) tick();
    n_chk++;
    if (en_total - e0 !== 0 || bus.rsp_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL range_oob_end: en=%0d valid=%b busy=%b required 0 0 0", en_total - e0, bus.rsp_valid_o, bus.busy_o);
    end
  endtask

  task automatic test_count_zero();
    mem[12] = 32'h0000_0008;
    issue_cmd(32'd12, 6'd0, 1'b1);
    get_beat(0, d, l, e, st);
    n_chk++;
    if (d !== 32'h8 || l !== 1'b1 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL count_zero_beat: data=%h last=%b err=%b required 00000008 1 0", d, l, e);
    end
    repeat (3) tick();
    n_chk++;
    if (bus.rsp_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL count_zero_end: valid=%b busy=%b required 0 0", bus.rsp_valid_o, bus.busy_o);
    end
  endtask

  task automatic test_abort();
    int n = 0;
    for (int i = 0; i < 4; i++) mem[10+i] = 32'hA0 + i;
    issue_cmd(32'd10, 6'd4, 1'b1);
    get_beat(0, d, l, e, st);
    while (bus.rsp_valid_o !== 1'b1 && n < 40) begin tick(); n++; end
    n_chk++;
    if (bus.rsp_valid_o !== 1'b1 || bus.rsp_data_o !== 32'hA1) begin
      n_fail++;
      $display("FAIL abort_beat2: valid=%b data=%h required 1 000000a1", bus.rsp_valid_o, bus.rsp_data_o);
    end
    bus.abort_i = 1'b1; bus.rsp_ready_i = 1'b1;
    tick();
    bus.abort_i = 1'b0; bus.rsp_ready_i = 1'b0;
    n_chk++;
    if (bus.rsp_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.cmd_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_state: valid=%b busy=%b rdy=%b required 0 0 1", bus.rsp_valid_o, bus.busy_o, bus.cmd_ready_o);
    end
    issue_cmd(32'd12, 6'd1, 1'b1);
    n_chk++;
    if (bus.dm_Mem_rd_en_o !== 1'b1 || bus.busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_reaccept: en=%b busy=%b required 1 1", bus.dm_Mem_rd_en_o, bus.busy_o);
    end
    get_beat(0, d, l, e, st);
    n_chk++;
    if (d !== 32'hA2 || l !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_next_beat: data=%h last=%b required 000000a2 1", d, l);
    end
  endtask

  task automatic test_reset_mid_burst();
    issue_cmd(32'd10, 6'd4, 1'b1);
    get_beat(0, d, l, e, st);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++;
    if ({bus.cmd_ready_o, bus.rsp_valid_o, bus.busy_o, bus.dm_Mem_rd_en_o, bus.rsp_last_o, bus.rsp_err_o} !== 6'b100000
        || bus.rsp_data_o !== 32'd0 || bus.dm_Mem_rd_address_o !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid: flags=%b data=%h addr=%h required 100000 0 0",
               {bus.cmd_ready_o, bus.rsp_valid_o, bus.busy_o, bus.dm_Mem_rd_en_o, bus.rsp_last_o, bus.rsp_err_o},
               bus.rsp_data_o, bus.dm_Mem_rd_address_o);
    end
    issue_cmd(32'd13, 6'd1, 1'b1);
    get_beat(0, d, l, e, st);
    n_chk++;
    if (d !== 32'hA3 || l !== 1'b1 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_recover: data=%h last=%b err=%b required 000000a3 1 0", d, l, e);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000 + i;
    test_reset();
    test_single_read();
    test_burst();
    test_backpressure();
    test_range_edge();
    test_count_zero();
    test_abort();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
